// File: rtl/xy_route_arbiter.sv
// rtl/xy_route_arbiter.sv - XY-routed round-robin switch allocator for a 5-port mesh router.
// Optional U-turn drop/flag logic is enabled by defining XY_ROUTE_UTURN_CHECK_EN.
module xy_route_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int PORT_N      = 5,
    parameter int COORD_WIDTH = 2,
    parameter int X_CORD      = 0,
    parameter int Y_CORD      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [PORT_N*DATA_WIDTH-1:0] head_data_i,
    input  logic [PORT_N-1:0]            head_valid_i,
    input  logic [PORT_N-1:0]            out_ready_i,
    output logic [PORT_N-1:0]            pop_o,
    output logic [$clog2(PORT_N)-1:0]    mux_in_sel_o,
    output logic [$clog2(PORT_N)-1:0]    mux_out_sel_o,
`ifdef XY_ROUTE_UTURN_CHECK_EN
    output logic                         err_o,
`endif
    output logic [PORT_N-1:0]            out_valid_o
);
    localparam int SEL_W = $clog2(PORT_N);
    localparam logic [COORD_WIDTH-1:0] X_C = COORD_WIDTH'(X_CORD);
    localparam logic [COORD_WIDTH-1:0] Y_C = COORD_WIDTH'(Y_CORD);
    localparam logic [SEL_W-1:0] P_LOCAL = SEL_W'(0);
    localparam logic [SEL_W-1:0] P_NORTH = SEL_W'(1);
    localparam logic [SEL_W-1:0] P_EAST  = SEL_W'(2);
    localparam logic [SEL_W-1:0] P_SOUTH = SEL_W'(3);
    localparam logic [SEL_W-1:0] P_WEST  = SEL_W'(4);

    logic [SEL_W-1:0]       route [PORT_N];
    logic [PORT_N-1:0]      eligible;
    logic [PORT_N-1:0]      uturn;
    logic [SEL_W-1:0]       rr_q;
    logic                   grant_valid;
    logic [SEL_W-1:0]       grant_idx;
    logic [COORD_WIDTH-1:0] dx [PORT_N];
    logic [COORD_WIDTH-1:0] dy [PORT_N];

    always_comb begin
        for (int p = 0; p < PORT_N; p++) begin
            dx[p] = head_data_i[DATA_WIDTH*p +: COORD_WIDTH];
            dy[p] = head_data_i[DATA_WIDTH*p+COORD_WIDTH +: COORD_WIDTH];
            if (dx[p] > X_C)      route[p] = P_EAST;
            else if (dx[p] < X_C) route[p] = P_WEST;
            else if (dy[p] > Y_C) route[p] = P_NORTH;
            else if (dy[p] < Y_C) route[p] = P_SOUTH;
            else                  route[p] = P_LOCAL;
        end
    end

    // The head of the input popped this cycle is stale, so it is masked out.
    always_comb begin
        for (int p = 0; p < PORT_N; p++) begin
            uturn[p] = (route[p] == SEL_W'(p)) && (p != 0);
`ifdef XY_ROUTE_UTURN_CHECK_EN
            eligible[p] = head_valid_i[p] && !pop_o[p] && (out_ready_i[route[p]] || uturn[p]);
`else
            eligible[p] = head_valid_i[p] && !pop_o[p] && out_ready_i[route[p]];
`endif
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= PORT_N; i++) begin
            if (!grant_valid && eligible[(int'(rr_q) + i) % PORT_N]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'((int'(rr_q) + i) % PORT_N);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q          <= SEL_W'(PORT_N - 1);
            pop_o         <= '0;
            out_valid_o   <= '0;
            mux_in_sel_o  <= '0;
            mux_out_sel_o <= '0;
`ifdef XY_ROUTE_UTURN_CHECK_EN
            err_o         <= 1'b0;
`endif
        end else if (grant_valid) begin
            rr_q          <= grant_idx;
            mux_in_sel_o  <= grant_idx;
            mux_out_sel_o <= route[grant_idx];
            pop_o         <= {{(PORT_N-1){1'b0}}, 1'b1} << grant_idx;
`ifdef XY_ROUTE_UTURN_CHECK_EN
            if (uturn[grant_idx]) begin
                out_valid_o <= '0;
                err_o       <= 1'b1;
            end else begin
                out_valid_o <= {{(PORT_N-1){1'b0}}, 1'b1} << route[grant_idx];
            end
`else
            out_valid_o   <= {{(PORT_N-1){1'b0}}, 1'b1} << route[grant_idx];
`endif
        end else begin
            pop_o       <= '0;
            out_valid_o <= '0;
        end
    end
endmodule

// File: tb/tb_xy_route_arbiter.sv
// tb/tb_xy_route_arbiter.sv - directed bench for xy_route_arbiter (dut0 at (0,0), dut1 at (1,1)).
module tb_xy_route_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] head_data = '0;
    logic [4:0]  head_valid = '0;
    logic [4:0]  out_ready = '0;
    logic [4:0]  pop0, pop1, ov0, ov1;
    logic [2:0]  isel0, isel1, osel0, osel1;
`ifdef XY_ROUTE_UTURN_CHECK_EN
    logic        err0, err1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xy_route_arbiter #(.X_CORD(0), .Y_CORD(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .head_data_i(head_data), .head_valid_i(head_valid),
        .out_ready_i(out_ready), .pop_o(pop0), .mux_in_sel_o(isel0), .mux_out_sel_o(osel0),
`ifdef XY_ROUTE_UTURN_CHECK_EN
        .err_o(err0),
`endif
        .out_valid_o(ov0));

    xy_route_arbiter #(.X_CORD(1), .Y_CORD(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .head_data_i(head_data), .head_valid_i(head_valid),
        .out_ready_i(out_ready), .pop_o(pop1), .mux_in_sel_o(isel1), .mux_out_sel_o(osel1),
`ifdef XY_ROUTE_UTURN_CHECK_EN
        .err_o(err1),
`endif
        .out_valid_o(ov1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] flit(input int x, input int y);
        logic [1:0] xx, yy;
        xx = 2'(x);
        yy = 2'(y);
        return {4'b0, yy, xx};
    endfunction

    task automatic set_port(input int p, input int x, input int y);
        head_data[8*p +: 8] = flit(x, y);
    endtask

    initial begin
        // Reset state and single local input.
        head_valid = 5'b00001;
        out_ready  = 5'b11111;
        set_port(0, 0, 0);
        do_reset();
        chk("rst_pop", pop0, 5'b00000);
        chk("rst_ov", ov0, 5'b00000);
        chk("rst_isel", isel0, 3'd0);
        chk("rst_osel", osel0, 3'd0);
        step();
        chk("t1_pop", pop0, 5'b00001);
        chk("t1_ov", ov0, 5'b00001);
        chk("t1_isel", isel0, 3'd0);
        chk("t1_osel", osel0, 3'd0);
        step();
        chk("t1_stale_pop", pop0, 5'b00000);
        chk("t1_stale_ov", ov0, 5'b00000);
        step();
        chk("t1_regrant_pop", pop0, 5'b00001);

        // Inputs 1,2,3 all to east: round-robin 1,2,3,1.
        head_valid = 5'b01110;
        set_port(1, 1, 0);
        set_port(2, 1, 0);
        set_port(3, 1, 0);
        do_reset();
        step();
        chk("rr_isel_a", isel0, 3'd1);
        chk("rr_pop_a", pop0, 5'b00010);
        chk("rr_ov_a", ov0, 5'b00100);
        chk("rr_osel_a", osel0, 3'd2);
        step();
        chk("rr_isel_b", isel0, 3'd2);
        chk("rr_ov_b", ov0, 5'b00100);
        step();
        chk("rr_isel_c", isel0, 3'd3);
        chk("rr_ov_c", ov0, 5'b00100);
        step();
        chk("rr_isel_d", isel0, 3'd1);
        chk("rr_pop_d", pop0, 5'b00010);

        // Blocked east output does not stall input 4.
        head_valid = 5'b10001;
        out_ready  = 5'b11011;
        set_port(0, 1, 0);
        set_port(4, 0, 1);
        do_reset();
        step();
        chk("blk_pop_a", pop0, 5'b10000);
        chk("blk_ov_a", ov0, 5'b00010);
        chk("blk_isel_a", isel0, 3'd4);
        chk("blk_osel_a", osel0, 3'd1);
        step();
        chk("blk_idle_pop", pop0, 5'b00000);
        chk("blk_idle_isel", isel0, 3'd4);
        chk("blk_idle_osel", osel0, 3'd1);
        step();
        chk("blk_pop_b", pop0, 5'b10000);
        out_ready = 5'b11111;
        step();
        chk("blk_rel_pop", pop0, 5'b00001);
        chk("blk_rel_ov", ov0, 5'b00100);
        chk("blk_rel_osel", osel0, 3'd2);

        // Routing at (1,1) via dut1.
        head_valid = 5'b00001;
        out_ready  = 5'b11111;
        set_port(0, 0, 3);
        do_reset();
        step();
        chk("rt_03", osel1, 3'd4);
        chk("rt_03_ov", ov1, 5'b10000);
        set_port(0, 2, 0);
        do_reset();
        step();
        chk("rt_20", osel1, 3'd2);
        set_port(0, 1, 3);
        do_reset();
        step();
        chk("rt_13", osel1, 3'd1);
        set_port(0, 1, 0);
        do_reset();
        step();
        chk("rt_10", osel1, 3'd3);
        chk("rt_10_ov", ov1, 5'b01000);
        set_port(0, 1, 1);
        do_reset();
        step();
        chk("rt_11", osel1, 3'd0);
        chk("rt_11_ov", ov1, 5'b00001);

        // Asynchronous reset mid-grant, then input 0 first.
        head_valid = 5'b00011;
        set_port(0, 0, 0);
        set_port(1, 0, 0);
        do_reset();
        step();
        chk("ar_pre_pop", pop0, 5'b00001);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pop", pop0, 5'b00000);
        chk("ar_ov", ov0, 5'b00000);
        step();
        rst = 1'b0;
        step();
        chk("ar_post_isel", isel0, 3'd0);
        chk("ar_post_pop", pop0, 5'b00001);

`ifdef XY_ROUTE_UTURN_CHECK_EN
        // West input heading to x=0: local at (0,0), U-turn at (1,1).
        head_valid = 5'b10000;
        out_ready  = 5'b00001;
        set_port(4, 0, 0);
        do_reset();
        chk("ut_err_rst", err1, 1'b0);
        step();
        chk("ut0_ov", ov0, 5'b00001);
        chk("ut0_err", err0, 1'b0);
        chk("ut1_pop", pop1, 5'b10000);
        chk("ut1_ov", ov1, 5'b00000);
        chk("ut1_err", err1, 1'b1);
        head_valid = 5'b00000;
        step();
        step();
        chk("ut1_err_sticky", err1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xy_route_arbiter.md
# xy_route_arbiter

Switch-allocation stage of the 5-port XY mesh router, directly upstream of the N-to-N crossbar. Looks at the head flit of every input FIFO, computes each head's output port by dimension-ordered XY routing, grants one input per cycle by round-robin, and drives the crossbar's input/output mux selects. Also produces per-port FIFO pop strobes and per-output valid strobes. Exactly one flit crosses the switch per cycle, matching the crossbar's single-transfer datapath.

## Interface
- DATA_WIDTH, 8: flit width; must be ≥ 2*COORD_WIDTH.
- PORT_N, 5: port count, fixed at 5. Port order: 0 local, 1 north, 2 east, 3 south, 4 west.
- COORD_WIDTH, 2: width of each destination coordinate field.
- X_CORD, 0: this router's column.
- Y_CORD, 0: this router's row.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- head_data_i  in  PORT_N*DATA_WIDTH  head flit of input FIFO p at bits [DATA_WIDTH*(p+1)-1 : DATA_WIDTH*p]. Dest x = flit[COORD_WIDTH-1:0]; dest y = flit[2*COORD_WIDTH-1:COORD_WIDTH].
- head_valid_i  in  PORT_N  input FIFO p is non-empty.
- out_ready_i  in  PORT_N  output p can accept one flit in the next cycle.
- pop_o  out  PORT_N  one-hot or zero; pops the granted input FIFO at the end of the cycle.
- mux_in_sel_o  out  $clog2(PORT_N)  crossbar input select.
- mux_out_sel_o  out  $clog2(PORT_N)  crossbar output select.
- out_valid_o  out  PORT_N  one-hot or zero; crossbar output p carries a valid flit this cycle.

## Operation
- Route per input p (combinational from head_data_i), using unsigned compares:
  - dx > X_CORD → east (2).
  - dx < X_CORD → west (4).
  - dx == X_CORD and dy > Y_CORD → north (1).
  - dx == X_CORD and dy < Y_CORD → south (3).
  - dx == X_CORD and dy == Y_CORD → local (0).
- Request from input p is eligible when all of these hold:
  - head_valid_i[p] = 1;
  - out_ready_i[route(p)] = 1;
  - p is not the input currently being popped (pop_o[p] = 0), because that head is stale this cycle.
- Round-robin pointer rr_q, width $clog2(PORT_N):
  - Search order is rr_q+1, rr_q+2, …, wrapping modulo PORT_N (4 wraps to 0).
  - The first eligible input wins.
  - On a grant to input k, rr_q ← k. With no grant, rr_q holds.
- Grant registers, at the edge following arbitration:
  - mux_in_sel_o ← k;
  - mux_out_sel_o ← route(k);
  - pop_o ← onehot(k);
  - out_valid_o ← onehot(route(k)).
- No eligible request:
  - pop_o and out_valid_o ← 0;
  - both selects hold their previous values.
- A head that stays ineligible because its output is not ready blocks only that input. Other inputs continue to be granted.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert):
  - pop_o = 0, out_valid_o = 0, mux_in_sel_o = 0, mux_out_sel_o = 0.
  - rr_q = PORT_N-1, so input 0 has first priority.
- Latency: head_valid_i rises in cycle N with its output ready → pop_o and out_valid_o high during cycle N+1. The crossbar passes the flit in cycle N+1; the FIFO pops at the end of N+1.
- Throughput:
  - One flit per cycle when at least two inputs alternate.
  - A single input alone gets one flit every 2 cycles (stale-head masking).
- out_ready_i is sampled only in the arbitration cycle. Downstream must guarantee that a sampled ready means it can take the flit in the next cycle.
- Reset mid-transfer: all strobes drop immediately. The flit is not popped and is re-arbitrated after reset.

## Configuration
- Macro XY_ROUTE_UTURN_CHECK_EN.
- Defined:
  - Adds port err_o (out, 1), reset 0.
  - A head whose route equals its own arrival port, with p ≠ 0, is a U-turn.
  - A U-turn is still arbitrated, but the grant pops it with out_valid_o = 0 (flit dropped), and err_o is set sticky until reset.
  - A dropped U-turn does not require out_ready_i.
- Not defined:
  - No err_o port and no check.
  - U-turn flits are forwarded normally.

## Test plan
- Reset, then only input 0 valid with dest (0,0) and all ready: cycle 1 gives pop_o = 00001, out_valid_o = 00001, mux_in_sel_o = 0, mux_out_sel_o = 0. Next grant comes 2 cycles later.
- Inputs 1, 2, 3 continuously valid with dest (1,0) at X_CORD = 0: grants cycle 1, 2, 3, 1, …. out_valid_o = 00100 every cycle; mux_out_sel_o = 2.
- Input 0 dest east with out_ready_i[2] = 0, input 4 dest north with out_ready_i[1] = 1: only input 4 granted. Raise ready[2] → input 0 granted in the next grant cycle.
- Route check at X_CORD = 1, Y_CORD = 1: dests (0,3)→4, (2,0)→2, (1,3)→1, (1,0)→3, (1,1)→0.
- Assert rst_i mid-grant: pop_o and out_valid_o go to 0 without waiting for a clock edge; after release, input 0 has first priority.
- With XY_ROUTE_UTURN_CHECK_EN at X_CORD = 0, a flit on input 4 (west) with dest x = 0 routes local and is not a U-turn. With X_CORD = 1 and dest x = 0, the flit is popped, out_valid_o stays 0, and err_o = 1 stays set.
